// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver. RXD is synchronised, sampled mid-bit and
//             the received byte is presented with a held-valid / read-ack
//             handshake, plus sticky overrun and framing-error flags.
//  Option   : define UART_RX_PARITY_EN for an even-parity bit between the
//             data bits and the stop bit (drives parity_err).
//  Revision : 1.0  initial release
// ============================================================================
module uart_rx #(
   parameter int CLK_FREQ_HZ = 12000000,
   parameter int BAUD_RATE   = 115200
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rd_ack,
   output logic       overrun,
   output logic       frame_err,
   output logic       parity_err
);

   localparam int CLKS_PER_BIT = CLK_FREQ_HZ / BAUD_RATE;
   localparam int c_CNT_W      = $clog2(CLKS_PER_BIT);
   // Half a bit (minus one) lands the start-bit sample in the middle of the bit.
   localparam logic [c_CNT_W-1:0] c_HALF_LOAD = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [c_CNT_W-1:0] c_FULL_LOAD = c_CNT_W'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_STOP   = 3'd3,
      S_BREAK  = 3'd4
`ifdef UART_RX_PARITY_EN
      ,
      S_PARITY = 3'd5
`endif
   } state_t;

   logic               r_sync1;
   logic               r_sync2;
   logic               w_rxs;
   state_t             r_state;
   state_t             w_state_next;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_cnt_next;
   logic               w_cnt_zero;
   logic [2:0]         r_idx;
   logic [2:0]         w_idx_next;
   logic [7:0]         r_shift;
   logic [7:0]         w_shift_next;
   logic               w_commit;
   logic               w_frame_set;
`ifdef UART_RX_PARITY_EN
   logic               r_par_bad;
   logic               w_par_bad_next;
`endif

   assign w_rxs      = r_sync2;
   assign w_cnt_zero = (r_cnt == '0);

   // Two-flop synchroniser for the asynchronous line; idles high.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= RXD;
         r_sync2 <= r_sync1;
      end
   end

   // Receiver state, baud counter, bit index and shift register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_cnt   <= w_cnt_next;
         r_idx   <= w_idx_next;
         r_shift <= w_shift_next;
      end
   end

   // Next-state logic: mid-bit sampling driven by the baud down-counter.
   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_idx_next   = r_idx;
      w_shift_next = r_shift;
      w_commit     = 1'b0;
      w_frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
      w_par_bad_next = r_par_bad;
`endif
      case (r_state)
         S_IDLE: begin
            if (!w_rxs) begin
               w_state_next = S_START;
               w_cnt_next   = c_HALF_LOAD;
            end
         end
         S_START: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - 1'b1;
            end else if (!w_rxs) begin
               w_state_next = S_DATA;
               w_cnt_next   = c_FULL_LOAD;
               w_idx_next   = 3'd0;
            end else begin
               // Line was high again at mid-start: treat as a glitch.
               w_state_next = S_IDLE;
            end
         end
         S_DATA: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - 1'b1;
            end else begin
               w_shift_next[r_idx] = w_rxs;
               w_cnt_next          = c_FULL_LOAD;
               if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  w_state_next = S_PARITY;
`else
                  w_state_next = S_STOP;
`endif
               end else begin
                  w_idx_next = r_idx + 3'd1;
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - 1'b1;
            end else begin
               // Even parity: data bits plus parity bit must XOR to zero.
               w_par_bad_next = w_rxs ^ (^r_shift);
               w_cnt_next     = c_FULL_LOAD;
               w_state_next   = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (!w_cnt_zero) begin
               w_cnt_next = r_cnt - 1'b1;
            end else if (w_rxs) begin
               w_commit     = 1'b1;
               w_state_next = S_IDLE;
            end else begin
               w_frame_set  = 1'b1;
               w_state_next = S_BREAK;
            end
         end
         S_BREAK: begin
            if (w_rxs) begin
               w_state_next = S_IDLE;
            end
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // Output handshake: commit beats rd_ack, rd_ack clears the sticky flags.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
         overrun   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (w_commit) begin
            rx_data  <= r_shift;
            rx_valid <= 1'b1;
            overrun  <= !rd_ack && (overrun || rx_valid);
         end else if (rd_ack) begin
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
         end
         if (w_frame_set) begin
            frame_err <= 1'b1;
         end else if (rd_ack) begin
            frame_err <= 1'b0;
         end
      end
   end

`ifdef UART_RX_PARITY_EN
   // Parity check result and its sticky flag, raised when the byte commits.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_par_bad  <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         r_par_bad <= w_par_bad_next;
         if (w_commit && r_par_bad) begin
            parity_err <= 1'b1;
         end else if (rd_ack) begin
            parity_err <= 1'b0;
         end
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule
`default_nettype wire
